board_test_button_reader: RTL and testbench

BOARD_TEST_BUTTON_READER -- requirements
Module: board_test_button_reader

---
 rtl/board_test_button_reader.sv | 119 +++++++++++
 tb/tb_board_test_button_reader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/board_test_button_reader.sv
// ============================================================================
// Module   : board_test_button_reader
// Brief    : Two-button reader: sync, debounce, press/release/long pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module board_test_button_reader #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int LONG_CYCLES     = 2621440
) (
  input  logic clk,
  input  logic rst,
  input  logic s1,
  input  logic s2,
  output logic s1_pressed,
  output logic s2_pressed,
  output logic s1_press,
  output logic s2_press,
  output logic s1_release,
  output logic s2_release,
  output logic s1_long,
  output logic s2_long,
  output logic both_press
);

  localparam int C_DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int C_HOLD_W = $clog2(64'(LONG_CYCLES) + 64'd1);
  localparam logic [C_DB_W-1:0]   C_DB_LAST  = C_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [C_HOLD_W-1:0] C_HOLD_MAX = C_HOLD_W'(LONG_CYCLES);
  localparam logic [C_HOLD_W-1:0] C_HOLD_PRE = C_HOLD_W'(LONG_CYCLES - 1);

  logic [1:0] w_raw;
  logic [1:0] w_pressed;
  logic [1:0] w_next_pressed;
  logic [1:0] w_press;
  logic [1:0] w_release;
  logic [1:0] w_long;
  logic       r_both;

  assign w_raw = {s2, s1};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_btn
      logic                r_meta;
      logic                r_sync;
      logic                r_pressed;
      logic                r_press;
      logic                r_release;
      logic                r_long;
      logic [C_DB_W-1:0]   r_db_cnt;
      logic [C_HOLD_W-1:0] r_hold_cnt;
      logic                w_differs;
      logic                w_toggle;

      // Raw pins are active-low; debounced state is kept active-high.
      assign w_differs         = (~r_sync) != r_pressed;
      assign w_toggle          = w_differs && (r_db_cnt == C_DB_LAST);
      assign w_next_pressed[i] = r_pressed ^ w_toggle;

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_meta     <= 1'b1;
          r_sync     <= 1'b1;
          r_pressed  <= 1'b0;
          r_press    <= 1'b0;
          r_release  <= 1'b0;
          r_long     <= 1'b0;
          r_db_cnt   <= '0;
          r_hold_cnt <= '0;
        end else begin
          r_meta    <= w_raw[i];
          r_sync    <= r_meta;
          r_pressed <= r_pressed ^ w_toggle;
          r_press   <= w_toggle & ~r_pressed;
          r_release <= w_toggle & r_pressed;

          if (!w_differs || w_toggle)
            r_db_cnt <= '0;
          else
            r_db_cnt <= r_db_cnt + 1'b1;

          // Hold counter saturates so the long pulse fires once per press.
          if (!r_pressed)
            r_hold_cnt <= '0;
          else if (r_hold_cnt != C_HOLD_MAX)
            r_hold_cnt <= r_hold_cnt + 1'b1;

          r_long <= r_pressed && (r_hold_cnt == C_HOLD_PRE);
        end
      end

      assign w_pressed[i] = r_pressed;
      assign w_press[i]   = r_press;
      assign w_release[i] = r_release;
      assign w_long[i]    = r_long;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst)
      r_both <= 1'b0;
    else
      r_both <= (&w_next_pressed) & ~(&w_pressed);
  end

  assign s1_pressed = w_pressed[0];
  assign s2_pressed = w_pressed[1];
  assign s1_press   = w_press[0];
  assign s2_press   = w_press[1];
  assign s1_release = w_release[0];
  assign s2_release = w_release[1];
  assign s1_long    = w_long[0];
  assign s2_long    = w_long[1];
  assign both_press = r_both;

endmodule

`default_nettype wire

// File: tb/tb_board_test_button_reader.sv
// ============================================================================
// Module   : tb_board_test_button_reader
// Brief    : Scoreboard bench for board_test_button_reader (DB=4, LONG=10).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_board_test_button_reader;

  localparam int DB = 4;
  localparam int LG = 10;

  localparam logic [6:0] P1   = 7'h01;
  localparam logic [6:0] P2   = 7'h02;
  localparam logic [6:0] R1   = 7'h04;
  localparam logic [6:0] R2   = 7'h08;
  localparam logic [6:0] L1   = 7'h10;
  localparam logic [6:0] L2   = 7'h20;
  localparam logic [6:0] BOTH = 7'h40;

  logic clk = 1'b0;
  logic rst;
  logic s1;
  logic s2;
  logic s1_pressed, s2_pressed, s1_press, s2_press;
  logic s1_release, s2_release, s1_long, s2_long, both_press;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [6:0] ev;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  logic [6:0] ev;

  board_test_button_reader #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s1        (s1),
    .s2        (s2),
    .s1_pressed(s1_pressed),
    .s2_pressed(s2_pressed),
    .s1_press  (s1_press),
    .s2_press  (s2_press),
    .s1_release(s1_release),
    .s2_release(s2_release),
    .s1_long   (s1_long),
    .s2_long   (s2_long),
    .both_press(both_press)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign ev = {both_press, s2_long, s1_long, s2_release, s1_release, s2_press, s1_press};

  // Every pulse vector the DUT shows must match the next expected event.
  always @(posedge clk) begin
    #1;
    if (ev != 7'h00) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got=%b required=none", cyc, ev);
      end else begin
        mon_e = expq.pop_front();
        if (mon_e.cyc != cyc || mon_e.ev != ev) begin
          errors++;
          $display("FAIL pulse_event got cyc=%0d ev=%b required cyc=%0d ev=%b",
                   cyc, ev, mon_e.cyc, mon_e.ev);
        end
      end
    end
  end

  task automatic push(input int c, input logic [6:0] e);
    exp_t x;
    x.cyc = c;
    x.ev  = e;
    expq.push_back(x);
  endtask

  task automatic wait_to(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h cyc=%0d", name, act, req, cyc);
    end
  endtask

  initial begin
    int c;
    rst = 1'b0;
    s1  = 1'b1;
    s2  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {23'd0, s1_pressed, s2_pressed, ev}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Single press latency, long press, release
    c = cyc;
    s1 = 1'b0;
    push(c + 6, P1);
    push(c + 16, L1);
    wait_to(c + 5);
    check("s1_lat_before", {31'd0, s1_pressed}, 32'd0);
    wait_to(c + 6);
    check("s1_lat_at", {31'd0, s1_pressed}, 32'd1);
    wait_to(c + 7);
    check("s1_press_one_cycle", {31'd0, s1_press}, 32'd0);
    wait_to(c + 21);
    s1 = 1'b1;
    push(c + 27, R1);
    wait_to(c + 27);
    check("s1_released", {31'd0, s1_pressed}, 32'd0);
    wait_to(c + 35);

    // Glitches of DB-1 cycles are filtered
    for (int r = 0; r < 5; r++) begin
      s1 = 1'b0;
      repeat (3) @(negedge clk);
      s1 = 1'b1;
      repeat (3) @(negedge clk);
      check("glitch_level", {31'd0, s1_pressed}, 32'd0);
    end
    repeat (8) @(negedge clk);

    // Exactly DB cycles low is accepted as a short press
    c = cyc;
    s1 = 1'b0;
    push(c + 6, P1);
    push(c + 10, R1);
    wait_to(c + 4);
    s1 = 1'b1;
    wait_to(c + 14);

    // Simultaneous press on both buttons
    c = cyc;
    s1 = 1'b0;
    s2 = 1'b0;
    push(c + 6, P1 | P2 | BOTH);
    push(c + 16, L1 | L2);
    wait_to(c + 6);
    check("both_levels", {30'd0, s1_pressed, s2_pressed}, 32'd3);
    wait_to(c + 20);
    s1 = 1'b1;
    s2 = 1'b1;
    push(c + 26, R1 | R2);
    wait_to(c + 30);

    // Staggered press: both_press coincides with s2_press
    c = cyc;
    s1 = 1'b0;
    push(c + 6, P1);
    push(c + 16, L1);
    wait_to(c + 20);
    s2 = 1'b0;
    push(c + 26, P2 | BOTH);
    push(c + 36, L2);
    wait_to(c + 40);
    s1 = 1'b1;
    s2 = 1'b1;
    push(c + 46, R1 | R2);
    wait_to(c + 50);

    // Reset mid-hold discards progress; held button re-reports as fresh press
    c = cyc;
    s2 = 1'b0;
    push(c + 6, P2);
    wait_to(c + 13);
    rst = 1'b0;
    wait_to(c + 14);
    check("reset_mid_hold", {23'd0, s1_pressed, s2_pressed, ev}, 32'd0);
    wait_to(c + 15);
    rst = 1'b1;
    push(c + 21, P2);
    push(c + 31, L2);
    wait_to(c + 20);
    check("s2_after_reset_before", {31'd0, s2_pressed}, 32'd0);
    wait_to(c + 21);
    check("s2_after_reset_at", {31'd0, s2_pressed}, 32'd1);
    wait_to(c + 35);
    s2 = 1'b1;
    push(c + 41, R2);
    wait_to(c + 48);

    while (expq.size() > 0) begin
      mon_e = expq.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_pulse got=none required cyc=%0d ev=%b", mon_e.cyc, mon_e.ev);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
